// File: rtl/branch_predictor.sv
// branch_predictor: PC-indexed saturating-counter direction predictor with tagged target buffer and branch statistics
// clk, reset              : clock, synchronous active-high reset
// lookup_pc -> predict_*  : combinational fetch-time prediction (hit, taken, next PC)
// update_*                : resolved branch from EX, applied on the rising edge
// branch_count, mispredict_count : saturating statistics since reset
module branch_predictor #(
  parameter int XLEN         = 32,
  parameter int ENTRIES      = 64,
  parameter int COUNTER_BITS = 2,
  parameter int TAG_BITS     = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            predict_hit,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_mispredict,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TOP = IDX + 2 + TAG_BITS;
  localparam logic [COUNTER_BITS-1:0] CTR_MAX = '1;
  localparam logic [COUNTER_BITS-1:0] CTR_WT  = COUNTER_BITS'(1) << (COUNTER_BITS - 1);
  localparam logic [COUNTER_BITS-1:0] CTR_WNT = CTR_WT - COUNTER_BITS'(1);
  logic [ENTRIES-1:0]      valid;
  logic [TAG_BITS-1:0]     tag    [ENTRIES];
  logic [XLEN-1:0]         target [ENTRIES];
  logic [COUNTER_BITS-1:0] ctr    [ENTRIES];
  logic [IDX-1:0]          l_idx, u_idx;
  logic [TAG_BITS-1:0]     l_tag, u_tag;
  logic                    u_hit;
  logic                    unused_pc;
  assign l_idx = lookup_pc[IDX+1:2];
  assign l_tag = lookup_pc[TOP-1:IDX+2];
  assign u_idx = update_pc[IDX+1:2];
  assign u_tag = update_pc[TOP-1:IDX+2];
  assign u_hit = valid[u_idx] && tag[u_idx] == u_tag;
  assign unused_pc = ^{update_pc[1:0], update_pc[XLEN-1:TOP]};
  always_comb begin
    predict_hit    = !reset && valid[l_idx] && tag[l_idx] == l_tag;
    predict_taken  = predict_hit && ctr[l_idx][COUNTER_BITS-1];
    predict_target = predict_taken ? target[l_idx] : lookup_pc + XLEN'(4);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid            <= '0;
      ctr              <= '{default: CTR_WNT};
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (update_valid) begin
      branch_count     <= branch_count + ((branch_count != '1) ? 32'd1 : 32'd0);
      mispredict_count <= mispredict_count + ((update_mispredict && mispredict_count != '1) ? 32'd1 : 32'd0);
      if (u_hit && update_taken) begin
        ctr[u_idx]    <= (ctr[u_idx] == CTR_MAX) ? CTR_MAX : ctr[u_idx] + COUNTER_BITS'(1);
        target[u_idx] <= update_target;
      end else if (u_hit) begin
        ctr[u_idx]    <= (ctr[u_idx] == '0) ? '0 : ctr[u_idx] - COUNTER_BITS'(1);
      end else if (update_taken) begin
        valid[u_idx]  <= 1'b1;
        tag[u_idx]    <= u_tag;
        target[u_idx] <= update_target;
        ctr[u_idx]    <= CTR_WT;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: randomized and directed check of branch_predictor against a table-level reference model
module tb_branch_predictor;
  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] lookup_pc = 0;
  logic        predict_hit, predict_taken;
  logic [31:0] predict_target;
  logic        update_valid = 0;
  logic [31:0] update_pc = 0;
  logic        update_taken = 0;
  logic [31:0] update_target = 0;
  logic        update_mispredict = 0;
  logic [31:0] branch_count, mispredict_count;
  int n_checks = 0;
  int n_fail = 0;
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  logic [31:0] m_bc, m_mc;
  always #5 clk = ~clk;
  branch_predictor dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .predict_hit(predict_hit), .predict_taken(predict_taken), .predict_target(predict_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit m_hit(input logic [31:0] pc);
    int i = (pc >> 2) % 64;
    return m_valid[i] && m_tag[i] == ((pc >> 8) & 255);
  endfunction
  function automatic void m_reset();
    foreach (m_valid[i]) begin
      m_valid[i] = 0;
      m_ctr[i] = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endfunction
  function automatic void m_update(input logic [31:0] pc, input logic t, input logic [31:0] tg, input logic mis);
    int i = (pc >> 2) % 64;
    if (m_bc != 32'hFFFF_FFFF) m_bc++;
    if (mis && m_mc != 32'hFFFF_FFFF) m_mc++;
    if (m_hit(pc)) begin
      m_ctr[i] = t ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      if (t) m_tgt[i] = tg;
    end else if (t) begin
      m_valid[i] = 1;
      m_tag[i] = (pc >> 8) & 255;
      m_tgt[i] = tg;
      m_ctr[i] = 2;
    end
  endfunction
  task automatic step(input logic rst, input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utg, input logic um);
    logic eh, et;
    reset = rst; lookup_pc = lpc; update_valid = uv; update_pc = upc;
    update_taken = ut; update_target = utg; update_mispredict = um;
    #1;
    eh = !rst && m_hit(lpc);
    et = eh && m_ctr[(lpc >> 2) % 64] >= 2;
    check("predict_hit", 32'(predict_hit), 32'(eh));
    check("predict_taken", 32'(predict_taken), 32'(et));
    check("predict_target", predict_target, et ? m_tgt[(lpc >> 2) % 64] : lpc + 32'd4);
    check("branch_count", branch_count, m_bc);
    check("mispredict_count", mispredict_count, m_mc);
    @(posedge clk);
    if (rst) m_reset();
    else if (uv) m_update(upc, ut, utg, um);
    @(negedge clk);
  endtask
  function automatic logic [31:0] rand_pc();
    logic [31:0] p = $urandom;
    p[7:2]  = 6'($urandom_range(0, 3));
    p[15:8] = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h81;
    return p;
  endfunction
  initial begin
    @(posedge clk);
    @(negedge clk);
    m_reset();
    step(1, 32'h100, 0, 0, 0, 0, 0);
    check("reset_hit", 32'(predict_hit), 0);
    check("reset_target", predict_target, 32'h104);
    step(0, 32'h100, 1, 32'h100, 1, 32'h80, 0);
    check("alloc_hit", 32'(predict_hit), 1);
    check("alloc_taken", 32'(predict_taken), 1);
    check("alloc_target", predict_target, 32'h80);
    repeat (2) step(0, 32'h100, 1, 32'h100, 0, 0, 0);
    check("ctr0_taken", 32'(predict_taken), 0);
    check("ctr0_hit", 32'(predict_hit), 1);
    check("ctr0_target", predict_target, 32'h104);
    repeat (4) step(0, 32'h100, 1, 32'h100, 1, 32'h80, 0);
    step(0, 32'h100, 1, 32'h100, 0, 0, 0);
    check("sat_then_nt_taken", 32'(predict_taken), 1);
    step(0, 32'h8100, 0, 0, 0, 0, 0);
    check("alias_miss", 32'(predict_hit), 0);
    step(0, 32'h8100, 1, 32'h8100, 1, 32'h200, 0);
    check("alias_target", predict_target, 32'h200);
    step(0, 32'h100, 0, 0, 0, 0, 0);
    check("alias_evicted", 32'(predict_hit), 0);
    step(0, 32'h100, 1, 32'h100, 1, 32'h80, 0);
    step(0, 32'h100, 1, 32'h100, 0, 0, 0);
    check("no_bypass_next", 32'(predict_taken), 0);
    step(1, 32'h100, 1, 32'h100, 1, 32'h80, 0);
    step(0, 32'h100, 1, 32'h300, 1, 32'h10, 0);
    step(0, 32'h100, 1, 32'h300, 0, 32'h10, 1);
    step(0, 32'h100, 1, 32'h300, 1, 32'h10, 0);
    check("bc3", branch_count, 3);
    check("mc1", mispredict_count, 1);
    step(1, 32'h100, 1, 32'h100, 1, 32'h80, 1);
    check("reset_bc", branch_count, 0);
    check("reset_hit2", 32'(predict_hit), 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 60) == 0, rand_pc(), 1'($urandom), rand_pc(), 1'($urandom), $urandom, 1'($urandom));
    force dut.branch_count = 32'hFFFF_FFFE;
    force dut.mispredict_count = 32'hFFFF_FFFE;
    #1;
    release dut.branch_count;
    release dut.mispredict_count;
    m_bc = 32'hFFFF_FFFE;
    m_mc = 32'hFFFF_FFFE;
    repeat (3) step(0, 32'h100, 1, 32'h100, 1, 32'h80, 1);
    check("bc_sat", branch_count, 32'hFFFF_FFFF);
    check("mc_sat", mispredict_count, 32'hFFFF_FFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
